// File: rtl/dht_reader_if.sv
// Host-side handshake bundle for the single-wire humidity/temperature reader.
// master = sensor-display logic, slave = dht_reader.
interface dht_reader_if;
  logic        start;
  logic        busy;
  logic        valid;
  logic [39:0] data;
  logic        error;
  logic [1:0]  err_code;

  modport master (
    output start,
    input  busy,
    input  valid,
    input  data,
    input  error,
    input  err_code
  );

  modport slave (
    input  start,
    output busy,
    output valid,
    output data,
    output error,
    output err_code
  );
endinterface

// File: rtl/dht_reader.sv
// Single-wire sensor controller: host start pulse, 40-bit pulse-width frame decode,
// checksum verification, timeout and checksum error reporting.
module dht_reader #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dht_in,
  output logic         dht_oe,
  dht_reader_if.slave  host
);

  localparam int              TICK_DIV    = CLK_FREQ_HZ / 1_000_000;
  localparam int              PRE_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [15:0]     START_CNT   = 16'(START_LOW_US);
  localparam logic [15:0]     TIMEOUT_CNT = 16'(TIMEOUT_US);
  localparam logic [15:0]     THRESH_CNT  = 16'(BIT_THRESH_US);
  localparam logic [5:0]      LAST_BIT    = 6'd39;

  localparam logic [1:0] ERR_NO_RESP  = 2'b01;
  localparam logic [1:0] ERR_BIT_TO   = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [15:0]       us_q, us_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [39:0]       shift_q, shift_d;
  logic [39:0]       data_q, data_d;
  logic              dht_oe_q, dht_oe_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              bit_val;
  logic              timed_out;
  logic [39:0]       shift_in;
  logic [7:0]        frame_byte [5];
  logic [7:0]        sum_byte;
  logic              sum_ok;

  // The high time is measured between two synchronised edges, so the
  // synchroniser delay appears on both ends and cancels out.
  assign bit_val   = (us_q > THRESH_CNT);
  assign timed_out = (us_q > TIMEOUT_CNT);
  assign shift_in  = {shift_q[38:0], bit_val};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_frame_bytes
      assign frame_byte[gi] = shift_in[gi*8 +: 8];
    end
  endgenerate

  assign sum_byte = frame_byte[4] + frame_byte[3] + frame_byte[2] + frame_byte[1];
  assign sum_ok   = (sum_byte == frame_byte[0]);

  always_comb begin
    sync1_d    = dht_in;
    sync2_d    = sync1_q;
    level_d    = sync2_q;
    rise_d     = sync2_q & ~level_q;
    fall_d     = ~sync2_q & level_q;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    err_code_d = err_code_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          state_d   = S_START_LOW;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      S_START_LOW: begin
        if (us_q >= START_CNT) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (fall_q) begin
          state_d = S_RESP_LOW;
        end else if (timed_out) begin
          state_d    = S_IDLE;
          error_d    = 1'b1;
          err_code_d = ERR_NO_RESP;
        end
      end
      S_RESP_LOW: begin
        if (rise_q) begin
          state_d = S_RESP_HIGH;
        end else if (timed_out) begin
          state_d    = S_IDLE;
          error_d    = 1'b1;
          err_code_d = ERR_NO_RESP;
        end
      end
      S_RESP_HIGH: begin
        if (fall_q) begin
          state_d = S_BIT_LOW;
        end else if (timed_out) begin
          state_d    = S_IDLE;
          error_d    = 1'b1;
          err_code_d = ERR_NO_RESP;
        end
      end
      S_BIT_LOW: begin
        if (rise_q) begin
          state_d = S_BIT_HIGH;
        end else if (timed_out) begin
          state_d    = S_IDLE;
          error_d    = 1'b1;
          err_code_d = ERR_BIT_TO;
        end
      end
      S_BIT_HIGH: begin
        if (fall_q) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == LAST_BIT) begin
            // Outputs are registered, so the verdict is computed here and
            // becomes visible during the CHECK cycle.
            state_d = S_CHECK;
            data_d  = shift_in;
            if (sum_ok) begin
              valid_d = 1'b1;
            end else begin
              error_d    = 1'b1;
              err_code_d = ERR_CHECKSUM;
            end
          end else begin
            state_d = S_BIT_LOW;
          end
        end else if (timed_out) begin
          state_d    = S_IDLE;
          error_d    = 1'b1;
          err_code_d = ERR_BIT_TO;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Time base restarts on every state change.
    if (state_d != state_q) begin
      pre_d = '0;
      us_d  = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      us_d  = (us_q == 16'hFFFF) ? us_q : us_q + 16'd1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
      us_d  = us_q;
    end

    dht_oe_d = (state_d == S_START_LOW);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      level_q    <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      pre_q      <= '0;
      us_q       <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      dht_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      pre_q      <= pre_d;
      us_q       <= us_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      dht_oe_q   <= dht_oe_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign dht_oe        = dht_oe_q;
  assign host.busy     = busy_q;
  assign host.valid    = valid_q;
  assign host.data     = data_q;
  assign host.error    = error_q;
  assign host.err_code = err_code_q;

endmodule

// File: tb/tb_dht_reader.sv
// Directed bench for dht_reader: a behavioural sensor drives the open-drain line
// with response and bit pulses; each scenario task checks its own results.
`timescale 1ns/1ps
module tb_dht_reader;

  localparam int US = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_low = 1'b0;
  logic dht_in;
  logic dht_oe;

  int tests = 0;
  int fails = 0;

  dht_reader_if ifc();

  // Open-drain line with pull-up: low if either side pulls.
  assign dht_in = !(dht_oe || sensor_low);

  dht_reader #(
    .CLK_FREQ_HZ  (10_000_000),
    .START_LOW_US (20),
    .TIMEOUT_US   (200),
    .BIT_THRESH_US(50)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .dht_in (dht_in),
    .dht_oe (dht_oe),
    .host   (ifc.slave)
  );

  always #50 clk = ~clk;

  int   valid_total   = 0;
  int   error_total   = 0;
  int   both_total    = 0;
  int   oe_rise_total = 0;
  logic oe_prev       = 1'b0;

  always @(negedge clk) begin
    if (ifc.valid === 1'b1) valid_total <= valid_total + 1;
    if (ifc.error === 1'b1) error_total <= error_total + 1;
    if (ifc.valid === 1'b1 && ifc.error === 1'b1) both_total <= both_total + 1;
    if (dht_oe === 1'b1 && oe_prev !== 1'b1) oe_rise_total <= oe_rise_total + 1;
    oe_prev <= dht_oe;
  end

  initial begin
    #15_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start();
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic start_and_release(input string name, output int oe_len);
    pulse_start();
    tests++;
    if (dht_oe !== 1'b1 || ifc.busy !== 1'b1) begin
      fails++;
      $display("FAIL %s start_latency: dht_oe=%b busy=%b, required 1/1", name, dht_oe, ifc.busy);
    end
    oe_len = 0;
    while (dht_oe === 1'b1 && oe_len < 1000) begin
      oe_len++;
      @(negedge clk);
    end
    tests++;
    if (oe_len < 190 || oe_len > 210) begin
      fails++;
      $display("FAIL %s start_pulse_len: %0d cycles, required 190..210", name, oe_len);
    end
  endtask

  task automatic sensor_send(input logic [39:0] frame, input int nbits,
                             input int hi0a, input int hi1a, input int hi0b, input int hi1b);
    #(10*US);
    sensor_low = 1'b1;
    #(80*US);
    sensor_low = 1'b0;
    #(80*US);
    for (int k = 0; k < nbits; k++) begin
      logic b;
      int   hi;
      b = frame[39-k];
      if (k < 8) hi = b ? hi1a : hi0a;
      else       hi = b ? hi1b : hi0b;
      sensor_low = 1'b1;
      #(50*US);
      sensor_low = 1'b0;
      #(hi*US);
    end
    sensor_low = 1'b1;
  endtask

  task automatic wait_for_pulse(input bit want_valid, input int max_cycles,
                                output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < max_cycles) begin
      @(negedge clk);
      n++;
      if (want_valid ? (ifc.valid === 1'b1) : (ifc.error === 1'b1)) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.start = 1'b0;
    sensor_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (dht_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b, required 0", dht_oe); end
    tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", ifc.busy); end
    tests++; if (ifc.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", ifc.valid); end
    tests++; if (ifc.error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b, required 0", ifc.error); end
    tests++; if (ifc.err_code !== 2'b00) begin fails++; $display("FAIL reset_err_code: got %b, required 00", ifc.err_code); end
    tests++; if (ifc.data !== 40'h0) begin fails++; $display("FAIL reset_data: got %h, required 0", ifc.data); end
    $display("[TB] reset: done");
  endtask

  task automatic test_reset_abort();
    pulse_start();
    tests++;
    if (dht_oe !== 1'b1 || ifc.busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_start: dht_oe=%b busy=%b, required 1/1", dht_oe, ifc.busy);
    end
    repeat (30) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    tests++;
    if (dht_oe !== 1'b1) begin fails++; $display("FAIL abort_ignored_start: dht_oe=%b, required 1", dht_oe); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (dht_oe !== 1'b0) begin fails++; $display("FAIL abort_oe: got %b, required 0", dht_oe); end
    tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b, required 0", ifc.busy); end
    tests++;
    if (ifc.valid !== 1'b0 || ifc.error !== 1'b0 || ifc.err_code !== 2'b00 || ifc.data !== 40'h0) begin
      fails++;
      $display("FAIL abort_outputs: valid=%b error=%b err_code=%b data=%h, required 0/0/00/0",
               ifc.valid, ifc.error, ifc.err_code, ifc.data);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL abort_stays_idle: busy=%b, required 0", ifc.busy); end
    $display("[TB] reset_abort: done");
  endtask

  task automatic test_no_sensor();
    int v0, oe_len, n;
    bit seen;
    v0 = valid_total;
    start_and_release("no_sensor", oe_len);
    wait_for_pulse(1'b0, 3000, n, seen);
    tests++; if (!seen) begin fails++; $display("FAIL no_sensor_error: no error pulse within 3000 cycles, required one"); end
    tests++; if (n < 2000 || n > 2500) begin fails++; $display("FAIL no_sensor_latency: %0d cycles, required 2000..2500", n); end
    tests++; if (ifc.err_code !== 2'b01) begin fails++; $display("FAIL no_sensor_code: got %b, required 01", ifc.err_code); end
    tests++; if (ifc.data !== 40'h0) begin fails++; $display("FAIL no_sensor_data: got %h, required 0", ifc.data); end
    tests++; if (dht_oe !== 1'b0) begin fails++; $display("FAIL no_sensor_oe: got %b, required 0", dht_oe); end
    repeat (3) @(negedge clk);
    tests++; if (valid_total != v0) begin fails++; $display("FAIL no_sensor_valid: %0d pulses, required 0", valid_total - v0); end
    $display("[TB] no_sensor: error after %0d cycles, err_code=%b", n, ifc.err_code);
  endtask

  task automatic test_good_frame();
    int v0, e0, r0, b0, oe_len, n;
    bit seen;
    v0 = valid_total; e0 = error_total; r0 = oe_rise_total; b0 = both_total;
    start_and_release("good", oe_len);
    fork
      sensor_send(40'h37_00_1A_00_51, 40, 27, 70, 27, 70);
      begin
        #(1000*US);
        pulse_start();
      end
    join
    wait_for_pulse(1'b1, 50, n, seen);
    tests++; if (!seen) begin fails++; $display("FAIL good_valid: no valid pulse within 50 cycles, required one"); end
    tests++; if (ifc.data !== 40'h37_00_1A_00_51) begin fails++; $display("FAIL good_data: got %h, required 37001a0051", ifc.data); end
    tests++; if (ifc.busy !== 1'b1) begin fails++; $display("FAIL good_busy_at_valid: got %b, required 1", ifc.busy); end
    @(negedge clk);
    tests++;
    if (ifc.busy !== 1'b0 || ifc.valid !== 1'b0) begin
      fails++;
      $display("FAIL good_after_valid: busy=%b valid=%b, required 0/0", ifc.busy, ifc.valid);
    end
    repeat (3) @(negedge clk);
    tests++; if (valid_total - v0 != 1) begin fails++; $display("FAIL good_valid_count: %0d, required 1", valid_total - v0); end
    tests++; if (error_total != e0) begin fails++; $display("FAIL good_error_count: %0d, required 0", error_total - e0); end
    tests++; if (oe_rise_total - r0 != 1) begin fails++; $display("FAIL ignored_start: %0d start pulses, required 1", oe_rise_total - r0); end
    tests++; if (both_total != b0) begin fails++; $display("FAIL good_exclusive: %0d cycles with valid and error, required 0", both_total - b0); end
    #(40*US);
    sensor_low = 1'b0;
    repeat (10) @(negedge clk);
    $display("[TB] good_frame: data=%h start_len=%0d", ifc.data, oe_len);
  endtask

  task automatic test_bad_checksum();
    int v0, oe_len, n;
    bit seen;
    logic [7:0] rh_int;
    v0 = valid_total;
    start_and_release("bad_sum", oe_len);
    // First byte uses 49/52 us high pulses to probe the decision threshold.
    sensor_send(40'h37_00_1A_00_52, 40, 49, 52, 27, 52);
    wait_for_pulse(1'b0, 50, n, seen);
    tests++; if (!seen) begin fails++; $display("FAIL bad_sum_error: no error pulse within 50 cycles, required one"); end
    tests++; if (ifc.err_code !== 2'b11) begin fails++; $display("FAIL bad_sum_code: got %b, required 11", ifc.err_code); end
    tests++; if (ifc.data !== 40'h37_00_1A_00_52) begin fails++; $display("FAIL bad_sum_data: got %h, required 37001a0052", ifc.data); end
    rh_int = ifc.data[39:32];
    tests++; if (rh_int !== 8'h37) begin fails++; $display("FAIL threshold_decode: got %h, required 37", rh_int); end
    @(negedge clk);
    tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL bad_sum_busy: got %b, required 0", ifc.busy); end
    repeat (3) @(negedge clk);
    tests++; if (valid_total != v0) begin fails++; $display("FAIL bad_sum_valid: %0d pulses, required 0", valid_total - v0); end
    #(40*US);
    sensor_low = 1'b0;
    repeat (10) @(negedge clk);
    $display("[TB] bad_checksum: data=%h err_code=%b", ifc.data, ifc.err_code);
  endtask

  task automatic test_stuck_bit();
    int v0, oe_len, n;
    bit seen;
    v0 = valid_total;
    start_and_release("stuck", oe_len);
    sensor_send(40'h0, 17, 27, 70, 27, 70);
    #(50*US);
    sensor_low = 1'b0;
    wait_for_pulse(1'b0, 4000, n, seen);
    tests++; if (!seen) begin fails++; $display("FAIL stuck_error: no error pulse within 4000 cycles, required one"); end
    tests++; if (n < 2000 || n > 2600) begin fails++; $display("FAIL stuck_latency: %0d cycles, required 2000..2600", n); end
    tests++; if (ifc.err_code !== 2'b10) begin fails++; $display("FAIL stuck_code: got %b, required 10", ifc.err_code); end
    tests++; if (ifc.data !== 40'h37_00_1A_00_52) begin fails++; $display("FAIL stuck_data: got %h, required 37001a0052", ifc.data); end
    repeat (3) @(negedge clk);
    tests++; if (valid_total != v0) begin fails++; $display("FAIL stuck_valid: %0d pulses, required 0", valid_total - v0); end
    tests++; if (dht_oe !== 1'b0 || ifc.busy !== 1'b0) begin fails++; $display("FAIL stuck_idle: dht_oe=%b busy=%b, required 0/0", dht_oe, ifc.busy); end
    $display("[TB] stuck_bit: error after %0d cycles, err_code=%b", n, ifc.err_code);
  endtask

  initial begin
    ifc.start = 1'b0;
    test_reset();
    test_reset_abort();
    test_no_sensor();
    test_good_frame();
    test_bad_checksum();
    test_stuck_bit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
